// File: rtl/timer_fsm_counter.sv
// timer_fsm_counter
// Stopwatch / kitchen-timer controller that owns its minutes:seconds count.
// It runs in one of two modes fixed at build time. In up mode it counts up
// from the value that was set. In down mode it counts down to 0:00 and can
// reload the preset. Pause keeps the sub-second tick phase, so resuming
// does not lose part of a second.
// Button inputs are single-cycle pulses from the debouncer. Every output is
// registered.

module timer_fsm_counter #(
    parameter int TICK_DIV   = 50000000,
    parameter int SEC_MAX    = 59,
    parameter int MIN_MAX    = 59,
    parameter int COUNT_DOWN = 0,
    parameter int SEC_W      = $clog2(SEC_MAX + 1),
    parameter int MIN_W      = $clog2(MIN_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             delete,
    input  logic             segDemand,
    input  logic             minDemand,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [2:0]       actualState,
    output logic             running,
    output logic             alarm
);

    // Width of the sub-second phase counter (TICK_DIV is at least 2).
    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [TICK_W-1:0] L_TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0]  L_SEC_MAX   = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0]  L_MIN_MAX   = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0]  L_SEC_ONE   = SEC_W'(1);
    localparam bit                L_DOWN      = (COUNT_DOWN != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SET   = 3'b001,
        ST_RUN   = 3'b010,
        ST_PAUSE = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

    // Registered state, time, preset and sub-second phase.
    state_t             r_state;
    logic [SEC_W-1:0]   r_sec;
    logic [MIN_W-1:0]   r_min;
    logic [SEC_W-1:0]   r_psec;
    logic [MIN_W-1:0]   r_pmin;
    logic [TICK_W-1:0]  r_tick;
    logic               r_running;
    logic               r_alarm;

    // Next-state values produced by the combinational process.
    state_t             w_state_nxt;
    logic [SEC_W-1:0]   w_sec_nxt;
    logic [MIN_W-1:0]   w_min_nxt;
    logic [SEC_W-1:0]   w_psec_nxt;
    logic [MIN_W-1:0]   w_pmin_nxt;
    logic [TICK_W-1:0]  w_tick_nxt;

    logic               w_zero;
    logic               w_tick_wrap;
    logic               w_demand;

    // Wrapping increment used while the time is being set. The two fields
    // are independent, so a seconds wrap does not carry into the minutes.
    function automatic logic [SEC_W-1:0] f_sec_inc(input logic [SEC_W-1:0] v);
        return (v == L_SEC_MAX) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] f_min_inc(input logic [MIN_W-1:0] v);
        return (v == L_MIN_MAX) ? '0 : v + 1'b1;
    endfunction

    assign w_zero      = (r_sec == '0) && (r_min == '0);
    assign w_tick_wrap = (r_tick == L_TICK_LAST);
    assign w_demand    = segDemand || minDemand;

    // Next-state, next-time and next-phase logic. Inputs are tested in the
    // order delete, stop, start, demand, so a higher-priority pulse masks
    // the lower ones in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_psec_nxt  = r_psec;
        w_pmin_nxt  = r_pmin;
        w_tick_nxt  = r_tick;

        case (r_state)
            ST_IDLE, ST_SET: begin
                if (delete) begin
                    w_state_nxt = ST_IDLE;
                    w_sec_nxt   = '0;
                    w_min_nxt   = '0;
                    w_tick_nxt  = '0;
                end else if (stop) begin
                    // stop has no action here but still masks start/demand
                    w_state_nxt = r_state;
                end else if (start) begin
                    // A down-counter cannot start from 0:00.
                    if (!(L_DOWN && w_zero)) begin
                        w_state_nxt = ST_RUN;
                        w_psec_nxt  = r_sec;
                        w_pmin_nxt  = r_min;
                        w_tick_nxt  = '0;
                    end
                end else if (w_demand) begin
                    // The pulse that leaves IDLE also applies its increment.
                    w_state_nxt = ST_SET;
                    if (segDemand) begin
                        w_sec_nxt = f_sec_inc(r_sec);
                    end
                    if (minDemand) begin
                        w_min_nxt = f_min_inc(r_min);
                    end
                end
            end

            ST_RUN: begin
                if (delete) begin
                    w_state_nxt = ST_IDLE;
                    w_sec_nxt   = '0;
                    w_min_nxt   = '0;
                    w_tick_nxt  = '0;
                end else if (stop) begin
                    // Freeze both the phase and the time on this edge.
                    w_state_nxt = ST_PAUSE;
                end else if (!w_tick_wrap) begin
                    w_tick_nxt = r_tick + 1'b1;
                end else begin
                    w_tick_nxt = '0;
                    if (L_DOWN) begin
                        if (r_sec == '0) begin
                            w_sec_nxt = L_SEC_MAX;
                            w_min_nxt = r_min - 1'b1;
                        end else begin
                            w_sec_nxt = r_sec - 1'b1;
                            // Enter DONE on the same edge that shows 0:00.
                            if ((r_min == '0) && (r_sec == L_SEC_ONE)) begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end else begin
                        if (r_sec != L_SEC_MAX) begin
                            w_sec_nxt = r_sec + 1'b1;
                        end else if (r_min != L_MIN_MAX) begin
                            w_sec_nxt = '0;
                            w_min_nxt = r_min + 1'b1;
                        end else begin
                            // Full scale reached: hold MIN_MAX:SEC_MAX.
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (delete) begin
                    w_state_nxt = ST_IDLE;
                    w_sec_nxt   = '0;
                    w_min_nxt   = '0;
                    w_tick_nxt  = '0;
                end else if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (start) begin
                    // Resume with the frozen phase; the tick is not cleared.
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DONE: begin
                if (delete) begin
                    w_state_nxt = ST_IDLE;
                    w_sec_nxt   = '0;
                    w_min_nxt   = '0;
                    w_tick_nxt  = '0;
                end else if (stop) begin
                    w_state_nxt = ST_DONE;
                end else if (start && L_DOWN) begin
                    // Kitchen-timer restart: reload the preset and rerun.
                    w_state_nxt = ST_RUN;
                    w_sec_nxt   = r_psec;
                    w_min_nxt   = r_pmin;
                    w_tick_nxt  = '0;
                end
            end

            default: begin
                // Undefined encodings recover to a clean IDLE.
                w_state_nxt = ST_IDLE;
                w_sec_nxt   = '0;
                w_min_nxt   = '0;
                w_tick_nxt  = '0;
            end
        endcase
    end

    // State, counters and flags. The flags are decoded from the next state,
    // so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sec     <= '0;
            r_min     <= '0;
            r_psec    <= '0;
            r_pmin    <= '0;
            r_tick    <= '0;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sec     <= w_sec_nxt;
            r_min     <= w_min_nxt;
            r_psec    <= w_psec_nxt;
            r_pmin    <= w_pmin_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_alarm   <= (w_state_nxt == ST_DONE);
        end
    end

    assign seconds     = r_sec;
    assign minutes     = r_min;
    assign actualState = r_state;
    assign running     = r_running;
    assign alarm       = r_alarm;

endmodule

// File: tb/tb_timer_fsm_counter.sv
// Bench for timer_fsm_counter. One up-mode and one down-mode instance
// share the same button stimulus. A reference model works on whole-second
// totals. For each driven cycle it queues the expected outputs of both
// instances. A monitor pops the queue after every rising edge and compares.
// Directed checks follow the test plan, and a randomized phase comes after.

module tb_timer_fsm_counter;

    localparam int TD = 4;
    localparam int SM = 59;
    localparam int MM = 59;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic del = 1'b0;
    logic seg = 1'b0;
    logic mnd = 1'b0;

    logic [5:0] up_sec, up_min, dn_sec, dn_min;
    logic [2:0] up_st, dn_st;
    logic       up_run, up_alm, dn_run, dn_alm;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;

    always #5 clk = ~clk;

    timer_fsm_counter #(.TICK_DIV(TD), .SEC_MAX(SM), .MIN_MAX(MM), .COUNT_DOWN(0)) u_up (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .delete(del),
        .segDemand(seg), .minDemand(mnd), .seconds(up_sec), .minutes(up_min),
        .actualState(up_st), .running(up_run), .alarm(up_alm)
    );

    timer_fsm_counter #(.TICK_DIV(TD), .SEC_MAX(SM), .MIN_MAX(MM), .COUNT_DOWN(1)) u_dn (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .delete(del),
        .segDemand(seg), .minDemand(mnd), .seconds(dn_sec), .minutes(dn_min),
        .actualState(dn_st), .running(dn_run), .alarm(dn_alm)
    );

    typedef struct packed {
        logic [2:0] st;
        int         sec;
        int         min;
        int         psec;
        int         pmin;
        int         phase;
    } mdl_t;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] sec;
        logic [5:0] min;
        logic       run;
        logic       alm;
    } obs_t;

    mdl_t m_up;
    mdl_t m_dn;
    obs_t q_up[$];
    obs_t q_dn[$];

    // Reference behaviour: time is handled as a total number of seconds,
    // the sub-second phase as a count of running clocks.
    function automatic mdl_t mstep(mdl_t m, bit dn, bit rs, bit s, bit p, bit d, bit sd, bit md);
        mdl_t n;
        int   tot;
        n = m;
        if (rs || !(m.st inside {S_IDLE, S_SET, S_RUN, S_PAUSE, S_DONE})) begin
            n = '0;
        end else if (d) begin
            n.st = S_IDLE; n.sec = 0; n.min = 0; n.phase = 0;
        end else if (m.st == S_IDLE || m.st == S_SET) begin
            if (p) begin
                n.st = m.st;
            end else if (s) begin
                if (!(dn && m.sec == 0 && m.min == 0)) begin
                    n.st = S_RUN; n.psec = m.sec; n.pmin = m.min; n.phase = 0;
                end
            end else if (sd || md) begin
                n.st = S_SET;
                if (sd) n.sec = (m.sec + 1) % (SM + 1);
                if (md) n.min = (m.min + 1) % (MM + 1);
            end
        end else if (m.st == S_RUN) begin
            if (p) begin
                n.st = S_PAUSE;
            end else begin
                n.phase = m.phase + 1;
                if (n.phase == TD) begin
                    n.phase = 0;
                    tot = m.min * (SM + 1) + m.sec;
                    if (!dn) begin
                        if (tot == MM * (SM + 1) + SM) n.st = S_DONE;
                        else tot = tot + 1;
                    end else begin
                        tot = tot - 1;
                        if (tot == 0) n.st = S_DONE;
                    end
                    n.sec = tot % (SM + 1);
                    n.min = tot / (SM + 1);
                end
            end
        end else if (m.st == S_PAUSE) begin
            if (!p && s) n.st = S_RUN;
        end else begin
            if (!p && s && dn) begin
                n.st = S_RUN; n.sec = m.psec; n.min = m.pmin; n.phase = 0;
            end
        end
        return n;
    endfunction

    function automatic obs_t to_obs(mdl_t m);
        obs_t o;
        o.st  = m.st;
        o.sec = 6'(m.sec);
        o.min = 6'(m.min);
        o.run = (m.st == S_RUN);
        o.alm = (m.st == S_DONE);
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Drive one clock of inputs (called at a falling edge), queue the model's
    // view of the outputs after the next rising edge, then wait for the next
    // falling edge.
    task automatic cyc(input bit rs, input bit s, input bit p, input bit d, input bit sd, input bit md);
        reset = rs; start = s; stop = p; del = d; seg = sd; mnd = md;
        m_up = mstep(m_up, 1'b0, rs, s, p, d, sd, md);
        m_dn = mstep(m_dn, 1'b1, rs, s, p, d, sd, md);
        q_up.push_back(to_obs(m_up));
        q_dn.push_back(to_obs(m_dn));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor: one expected entry per rising edge for each instance.
    always @(posedge clk) begin
        obs_t eu, ed, au, ad;
        #2;
        if (q_up.size() > 0 && q_dn.size() > 0) begin
            eu = q_up.pop_front();
            ed = q_dn.pop_front();
            au = '{st: up_st, sec: up_sec, min: up_min, run: up_run, alm: up_alm};
            ad = '{st: dn_st, sec: dn_sec, min: dn_min, run: dn_run, alm: dn_alm};
            n_cyc++;
            n_cmp++;
            if (au !== eu) begin
                n_bad++;
                $display("FAIL sb_up cyc=%0d: got st=%0d %0d:%0d run=%0b alm=%0b, required st=%0d %0d:%0d run=%0b alm=%0b",
                         n_cyc, au.st, au.min, au.sec, au.run, au.alm, eu.st, eu.min, eu.sec, eu.run, eu.alm);
            end
            n_cmp++;
            if (ad !== ed) begin
                n_bad++;
                $display("FAIL sb_dn cyc=%0d: got st=%0d %0d:%0d run=%0b alm=%0b, required st=%0d %0d:%0d run=%0b alm=%0b",
                         n_cyc, ad.st, ad.min, ad.sec, ad.run, ad.alm, ed.st, ed.min, ed.sec, ed.run, ed.alm);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        m_up = '0;
        m_dn = '0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_up_state", up_st, 0);
        chk("reset_up_flags", {up_run, up_alm}, 0);
        chk("reset_dn_time", {dn_min, dn_sec}, 0);

        // 1. Up-mode count, pause and resume; down mode refuses start at 0:00
        cyc(0, 1, 0, 0, 0, 0);
        chk("dn_start_at_zero_ignored", dn_st, S_IDLE);
        idle(240);
        chk("up_240clk_min", up_min, 1);
        chk("up_240clk_sec", up_sec, 0);
        cyc(0, 0, 1, 0, 0, 0);
        idle(20);
        chk("up_pause_state", up_st, S_PAUSE);
        chk("up_pause_time", up_min * 100 + up_sec, 100);
        cyc(0, 1, 0, 0, 0, 0);
        idle(3);
        chk("up_resume_3clk_sec", up_sec, 0);
        idle(1);
        chk("up_resume_4clk_sec", up_sec, 1);

        // 2. Setting, including both demands in one cycle, then seconds wrap
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("set_up_time", up_min * 100 + up_sec, 203);
        chk("set_dn_state", dn_st, S_SET);
        repeat (57) cyc(0, 0, 0, 0, 1, 0);
        chk("set_wrap_sec", up_sec, 0);
        chk("set_wrap_min", up_min, 2);

        // 3. Down mode runs 0:02 to DONE, then start reloads the preset
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(7);
        chk("dn_7clk_sec", dn_sec, 1);
        idle(1);
        chk("dn_done_state", dn_st, S_DONE);
        chk("dn_done_flags", {dn_run, dn_alm}, 1);
        chk("dn_done_time", {dn_min, dn_sec}, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("dn_reload_state", dn_st, S_RUN);
        chk("dn_reload_sec", dn_sec, 2);

        // 4. Delete during down-mode RUN at 0:01
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1, 0, 0);
        chk("dn_delete_state", dn_st, S_IDLE);
        chk("dn_delete_time", {dn_min, dn_sec}, 0);

        // 5. Up mode full-scale hold; simultaneous stop+start gives PAUSE
        repeat (58) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("set_5958", up_min * 100 + up_sec, 5958);
        cyc(0, 1, 0, 0, 0, 0);
        idle(8);
        chk("up_full_state", up_st, S_DONE);
        chk("up_full_time", up_min * 100 + up_sec, 5959);
        chk("up_full_alarm", up_alm, 1);
        chk("dn_borrowless_time", dn_min * 100 + dn_sec, 5956);
        cyc(0, 1, 1, 0, 0, 0);
        chk("stop_beats_start", dn_st, S_PAUSE);

        // 6. Reset together with delete mid-RUN
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 1, 0, 0);
        chk("rst_dn_state", dn_st, 0);
        chk("rst_dn_all", {dn_min, dn_sec, dn_run, dn_alm}, 0);

        // Randomized phase: short set/run sequences with random pulses
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       cyc(0, 0, 0, 1, 0, 0);
            else if (r < 6)  cyc(0, 0, 1, 0, 0, 0);
            else if (r < 14) cyc(0, 1, 0, 0, 0, 0);
            else if (r < 26) cyc(0, 0, 0, 0, 1, 0);
            else if (r < 34) cyc(0, 0, 0, 0, 0, 1);
            else if (r < 37) cyc(0, 0, 0, 0, 1, 1);
            else if (r < 38) cyc(1, 0, 0, 0, 0, 0);
            else             cyc(0, 0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        chk("scoreboard_drained", q_up.size() + q_dn.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_fsm_counter.md
Name: timer_fsm_counter

Overview:
Parametrised successor to the stopwatch/timer control state machine: the FSM now owns the minutes:seconds counter instead of driving an external one. It supports count-up (stopwatch) or count-down (kitchen timer) mode, adds a DONE/alarm state, and adds pause/resume with the sub-second phase preserved. It sits between the debounced button pulses and the VGA digit renderer, which reads `minutes`, `seconds` and `actualState`.

Parameters:
- TICK_DIV, 50000000: clock cycles per counted second; minimum 2.
- SEC_MAX, 59: highest seconds value; wraps to 0.
- MIN_MAX, 59: highest minutes value.
- COUNT_DOWN, 0: 0 = count up, 1 = count down from the preset.
- SEC_W, $clog2(SEC_MAX+1): seconds width (derived).
- MIN_W, $clog2(MIN_MAX+1): minutes width (derived).

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse.
- stop  in  1  single-cycle pulse.
- delete  in  1  single-cycle pulse.
- segDemand  in  1  single-cycle pulse: increment seconds while setting.
- minDemand  in  1  single-cycle pulse: increment minutes while setting.
- seconds  out  SEC_W  current seconds, binary.
- minutes  out  MIN_W  current minutes, binary.
- actualState  out  3  current state encoding.
- running  out  1  high while in RUN.
- alarm  out  1  high while in DONE.

Behaviour:
- Decided interface facts: one clock, `clk`; `reset` is synchronous and active-high. All outputs are registered and update on the rising edge of `clk`.
- Reset: the state goes to IDLE.
  - seconds = 0, minutes = 0, preset = 0:0, tick counter = 0.
  - running = 0, alarm = 0, actualState = 3'b000.
- States and encodings: IDLE = 000, SET = 001, RUN = 010, PAUSE = 011, DONE = 100. Unused codes go to IDLE on the next clock.
- Input priority within a cycle: reset > delete > stop > start > segDemand/minDemand.
- IDLE:
  - start → RUN. In COUNT_DOWN mode, start is ignored if the count is 0:0.
  - segDemand or minDemand → SET, and that same pulse applies its increment.
- SET:
  - segDemand: seconds = (seconds == SEC_MAX) ? 0 : seconds+1.
  - minDemand: same rule on minutes with MIN_MAX.
  - Both pulses in the same cycle: both fields increment; there is no carry between fields.
  - start → RUN and the current value is latched as the preset. In COUNT_DOWN mode, start at 0:0 is ignored.
  - delete → IDLE with the count cleared.
- RUN:
  - The tick counter increments every clock.
  - At TICK_DIV-1 the tick counter returns to 0 and the time steps by one second.
  - Up mode: seconds wrap at SEC_MAX into minutes+1. Stepping from MIN_MAX:SEC_MAX → DONE, with the display held at MIN_MAX:SEC_MAX.
  - Down mode: seconds at 0 borrow, giving SEC_MAX and minutes-1. Reaching 0:0 → DONE on the same edge that shows 0:0.
  - stop → PAUSE; the tick counter and time freeze on that edge.
  - delete → IDLE with the count cleared.
  - Demand pulses are ignored.
- PAUSE:
  - start → RUN, resuming the tick counter from its frozen value (no phase loss).
  - delete → IDLE with the count cleared.
  - stop and demand pulses are ignored.
- DONE:
  - alarm = 1 and the time is held.
  - start (down mode only) reloads the preset, clears the tick counter and → RUN.
  - delete → IDLE with the count cleared.
  - Other inputs are ignored.
- Tick counter clearing: the tick counter is cleared whenever RUN is entered from IDLE, SET or DONE, and whenever delete is accepted.
- Flag outputs: running = (next state == RUN) and alarm = (next state == DONE), both registered with the state. actualState always equals the state register.
- Latency: a pulse at edge N is reflected in the state and counters after edge N. The first second step occurs TICK_DIV clocks after entering RUN.
- Reset mid-operation overrides every input and state in the same cycle.

Test Plan (TICK_DIV=4, SEC_MAX=59, MIN_MAX=59):
1. Up mode: reset, then start; run 240 clocks → 1:00. stop, wait 20 clocks → still 1:00, actualState=011. start, then 4 clocks → 1:01.
2. Setting: from IDLE, 3 segDemand pulses and 2 minDemand pulses, including one cycle with both asserted → 2:03, actualState=001. 57 further segDemand pulses → seconds wraps to 0, minutes stays 2.
3. Down mode (COUNT_DOWN=1): set 0:02, then start; after 8 clocks → 0:00, DONE, alarm=1, running=0. start → 0:02, RUN.
4. Down mode: start in IDLE at 0:00 → stays IDLE. delete during RUN at 0:01 → IDLE, 0:00, tick counter 0.
5. Up mode, wrap boundary: preset 59:58, then start; after 8 clocks → DONE with 59:59 held. Simultaneous stop+start in RUN → PAUSE (stop wins).
6. reset asserted mid-RUN while delete is also asserted → next edge gives IDLE, 0:00, running=0, alarm=0, actualState=000.
